ripple_count_sampler: RTL and testbench

Consumes the raw output of the 4-bit asynchronous ripple counter and brings it safely into the system clock domain. It synchronises the glitch-prone count and filters it until stable. It publishes a clean count, extends it to a wider total by counting wrap-arounds, and flags compare matches and missed codes. It sits directly downstream of the ripple counter; all consumers of the count read this block, never the counter itself.

---
 rtl/count_pkg.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/ripple_count_sampler.sv | 124 ++++++++++++
 tb/tb_ripple_count_sampler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared defaults and helpers for the ripple-counter sampling path.
// Kept tiny so both the sampler and its bench agree on widths.
package count_pkg;

  localparam int DEF_WIDTH         = 4;
  localparam int DEF_EXT_WIDTH     = 8;
  localparam int DEF_STABLE_CYCLES = 2;

  // Run counter width; wide enough for the largest legal STABLE_CYCLES (7).
  localparam int RUN_W = 3;

  // Returns x+1 modulo 2^width; callers truncate to their own width.
  function automatic logic [31:0] inc_wrap(input logic [31:0] x, input int width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (x + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus whose bits are sampled independently;
// the downstream stability filter hides any cross-bit skew.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/ripple_count_sampler.sv
// Brings the asynchronous ripple count into clk, filters it until stable,
// extends it by counting wrap-arounds and flags compare hits and skipped codes.
module ripple_count_sampler
  import count_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int EXT_WIDTH     = DEF_EXT_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     cnt_in,
  input  logic [EXT_WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0]     cnt_out,
  output logic [EXT_WIDTH-1:0] cnt_ext,
  output logic                 upd,
  output logic                 wrap,
  output logic                 match,
  output logic                 skip_err
);

  localparam int WRAP_W = EXT_WIDTH - WIDTH;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

  generate
    if (EXT_WIDTH <= WIDTH) begin : g_bad_ext
      $error("EXT_WIDTH must exceed WIDTH");
    end
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 7) begin : g_bad_stable
      $error("STABLE_CYCLES must be within 1..7");
    end
  endgenerate

  logic [WIDTH-1:0]  s2;
  logic [WIDTH-1:0]  s_prev_q;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [WIDTH-1:0]  cnt_out_q, cnt_out_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              upd_q, upd_d;
  logic              wrap_q, wrap_d;
  logic              skip_q, skip_d;
  logic              match_q, match_d;
  logic [WIDTH-1:0]  cnt_inc;
  logic              accept;
  logic              in_seq;
  logic              rolls;

  sync_2ff #(
    .W (WIDTH)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (cnt_in),
    .q_o (s2)
  );

  assign cnt_inc = WIDTH'(inc_wrap(32'(cnt_out_q), WIDTH));

  // A saturated run still describes the previous s2 on the cycle s2 changes,
  // so acceptance also requires s2 to equal s_prev.
  assign accept = (run_q == RUN_MAX) && (s2 == s_prev_q) && (s2 != cnt_out_q);
  assign in_seq = (s2 == cnt_inc);
  assign rolls  = in_seq && (cnt_out_q == '1) && (s2 == '0);

  always_comb begin
    run_d      = run_q;
    cnt_out_d  = cnt_out_q;
    wrap_cnt_d = wrap_cnt_q;
    upd_d      = 1'b0;
    wrap_d     = 1'b0;
    skip_d     = skip_q;

    if (s2 == s_prev_q) begin
      if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_W'(1);
      end
    end else begin
      run_d = '0;
    end

    if (accept) begin
      cnt_out_d = s2;
      upd_d     = 1'b1;
      if (!in_seq) begin
        skip_d = 1'b1;
      end else if (rolls) begin
        wrap_d     = 1'b1;
        wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
      end
    end

    match_d = ({wrap_cnt_d, cnt_out_d} == cmp_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q   <= '0;
      run_q      <= '0;
      cnt_out_q  <= '0;
      wrap_cnt_q <= '0;
      upd_q      <= 1'b0;
      wrap_q     <= 1'b0;
      skip_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      s_prev_q   <= s2;
      run_q      <= run_d;
      cnt_out_q  <= cnt_out_d;
      wrap_cnt_q <= wrap_cnt_d;
      upd_q      <= upd_d;
      wrap_q     <= wrap_d;
      skip_q     <= skip_d;
      match_q    <= match_d;
    end
  end

  assign cnt_out  = cnt_out_q;
  assign cnt_ext  = {wrap_cnt_q, cnt_out_q};
  assign upd      = upd_q;
  assign wrap     = wrap_q;
  assign match    = match_q;
  assign skip_err = skip_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Bench for ripple_count_sampler: steps the raw count, predicts each accept
// (cycle, value, flags) into a queue and checks it when upd fires.
module tb_ripple_count_sampler;

  localparam int E_W = 31;  // {cyc[15:0], cnt[3:0], ext[7:0], wrap, skip, match}

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic [7:0] cmp_val;
  logic [3:0] cnt_out;
  logic [7:0] cnt_ext;
  logic       upd;
  logic       wrap;
  logic       match;
  logic       skip_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wraps_seen = 0;

  logic [E_W-1:0] exp_q[$];
  logic [E_W-1:0] e;

  logic [3:0] exp_cnt;
  logic [3:0] exp_wrap_cnt;
  logic       exp_skip;
  int         exp_wraps;

  ripple_count_sampler dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_in   (cnt_in),
    .cmp_val  (cmp_val),
    .cnt_out  (cnt_out),
    .cnt_ext  (cnt_ext),
    .upd      (upd),
    .wrap     (wrap),
    .match    (match),
    .skip_err (skip_err)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive a raw value and hold it; called and returns on a negedge.
  task automatic drive_raw(input logic [3:0] v, input int hold);
    cnt_in = v;
    repeat (hold) @(negedge clk);
  endtask

  function automatic logic [E_W-1:0] pack(input int c, input logic [3:0] cn, input logic [7:0] ex,
                                          input logic wr, input logic sk, input logic mt);
    return {c[15:0], cn, ex, wr, sk, mt};
  endfunction

  // Drive a held value and predict its accept five edges after capture.
  task automatic drive_step(input logic [3:0] v, input int hold);
    logic       sk;
    logic       wr;
    logic [3:0] nxt;
    logic [7:0] ext;
    nxt = exp_cnt + 4'd1;
    if (v != exp_cnt) begin
      sk = (v != nxt);
      wr = !sk && (exp_cnt == 4'hf) && (v == 4'h0);
      if (sk) exp_skip = 1'b1;
      if (wr) begin
        exp_wrap_cnt = exp_wrap_cnt + 4'd1;
        exp_wraps++;
      end
      exp_cnt = v;
      ext = {exp_wrap_cnt, exp_cnt};
      exp_q.push_back(pack(cyc + 6, exp_cnt, ext, wr, exp_skip, ext == cmp_val));
    end
    drive_raw(v, hold);
  endtask

  // scoreboard: every upd pops one prediction
  always @(negedge clk) begin
    if (!rst && wrap && !upd) chk("wrap_without_upd", wrap, 1'b0);
    if (!rst && upd) begin
      if (wrap) wraps_seen++;
      if (exp_q.size() == 0) begin
        chk("spurious_upd", upd, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("upd_cycle", cyc[15:0], e[30:15]);
        chk("cnt_out",   cnt_out,   e[14:11]);
        chk("cnt_ext",   cnt_ext,   e[10:3]);
        chk("wrap",      wrap,      e[2]);
        chk("skip_err",  skip_err,  e[1]);
        chk("match",     match,     e[0]);
      end
    end
  end

  initial begin : main
    int c;
    rst = 1'b1;
    cnt_in = 4'h0;
    cmp_val = 8'h00;
    exp_cnt = 4'h0;
    exp_wrap_cnt = 4'h0;
    exp_skip = 1'b0;
    exp_wraps = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_cnt_out", cnt_out, 4'h0);
    chk("rst_cnt_ext", cnt_ext, 8'h00);
    chk("rst_upd", upd, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_skip", skip_err, 1'b0);
    chk("rst_match", match, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("match_after_rst", match, 1'b1);
    cmp_val = 8'h13;

    // basic steps 0 -> 1 -> 2
    drive_step(4'h0, 10);
    drive_step(4'h1, 10);
    drive_step(4'h2, 10);
    chk("skip_after_steps", skip_err, 1'b0);

    // short glitch to 3 must be ignored
    drive_raw(4'h3, 2);
    drive_step(4'h2, 10);
    chk("glitch_cnt_out", cnt_out, 4'h2);

    // two full wraps; passes 0x13 for the compare check
    for (int v = 3; v < 16; v++) drive_step(4'(v), 10);
    drive_step(4'h0, 10);
    for (int v = 1; v < 16; v++) drive_step(4'(v), 10);
    drive_step(4'h0, 10);
    chk("ext_after_wraps", cnt_ext, 8'h20);
    chk("skip_after_wraps", skip_err, 1'b0);

    // compare value change alone lands one cycle later
    chk("match_before_cmp", match, 1'b0);
    cmp_val = 8'h20;
    chk("match_cmp_same_cycle", match, 1'b0);
    @(negedge clk);
    chk("match_cmp_next_cycle", match, 1'b1);

    // skipped code 5 -> 8, sticky afterwards
    for (int v = 1; v < 6; v++) drive_step(4'(v), 10);
    drive_step(4'h8, 10);
    drive_step(4'h9, 10);
    chk("skip_sticky", skip_err, 1'b1);

    // reset in the middle of filtering 6 -> 7
    drive_step(4'h6, 10);
    c = cyc;
    cnt_in = 4'h7;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cnt_out", cnt_out, 4'h0);
    chk("midrst_cnt_ext", cnt_ext, 8'h00);
    chk("midrst_upd", upd, 1'b0);
    chk("midrst_wrap", wrap, 1'b0);
    chk("midrst_skip", skip_err, 1'b0);
    chk("midrst_match", match, 1'b0);
    rst = 1'b0;
    exp_cnt = 4'h7;
    exp_wrap_cnt = 4'h0;
    exp_skip = 1'b1;
    exp_q.push_back(pack(c + 10, 4'h7, 8'h07, 1'b0, 1'b1, 8'h07 == cmp_val));
    repeat (12) @(negedge clk);

    chk("pending_updates", exp_q.size(), 0);
    chk("wrap_pulses", wraps_seen, exp_wraps);
    chk("final_cnt_out", cnt_out, 4'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
